// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the fetch PC, issues one imem request at a time and buffers responses in a DEPTH-entry prefetch FIFO.
// Latency: a response pushed on imem_rvalid is visible to decode the next cycle; 1-cycle memory gives one instruction every 2 cycles.
// Backpressure: instr_ready low holds the head; no request is issued once the FIFO has no free entry. PCSrc flushes and redirects.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module instr_fetch_unit #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] Instr,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus8,
`ifdef FETCH_PERF_EN
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed,
`endif
   input  logic        PCSrc,
   input  logic [31:0] branch_target
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   fifo_instr [DEPTH];
   logic [31:0]   fifo_pc    [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [CW-1:0] count;

   logic [31:0]   pc_fetch;
   logic [31:0]   req_pc;        // address of the request currently in flight
   logic          outstanding;
   logic          drop;          // in-flight response belongs to a flushed path

   logic          issue;
   logic          resp;
   logic          push;
   logic          pop;

   // Space is checked before issue so a response can always be pushed.
   assign issue = !reset && !outstanding && !PCSrc && (count < FULL);
   assign resp  = imem_rvalid && outstanding;
   assign push  = resp && !drop && !PCSrc;
   assign pop   = instr_valid && instr_ready && !PCSrc;

   assign imem_req    = issue;
   assign imem_addr   = pc_fetch;
   assign instr_valid = (count != '0);
   assign Instr       = instr_valid ? fifo_instr[rd_ptr] : 32'h0;
   assign PCF         = instr_valid ? fifo_pc[rd_ptr] : 32'h0;
   assign PCPlus8     = instr_valid ? (fifo_pc[rd_ptr] + 32'd8) : 32'h0;

   // Fetch PC and request bookkeeping; a flush reloads the PC and marks an in-flight word stale.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_fetch    <= RESET_PC;
         req_pc      <= RESET_PC;
         outstanding <= 1'b0;
         drop        <= 1'b0;
      end else if (PCSrc) begin
         pc_fetch    <= branch_target & 32'hFFFF_FFFC;
         outstanding <= outstanding && !imem_rvalid;
         drop        <= outstanding && !imem_rvalid;
      end else begin
         if (resp) begin
            outstanding <= 1'b0;
            drop        <= 1'b0;
         end
         if (issue) begin
            outstanding <= 1'b1;
            req_pc      <= pc_fetch;
            pc_fetch    <= pc_fetch + 32'd4;
         end
      end
   end

   // FIFO pointers and occupancy; flush empties the queue.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (PCSrc) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // FIFO storage; contents are only observed while count is non-zero.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_instr[wr_ptr] <= imem_rdata;
         fifo_pc[wr_ptr]    <= req_pc;
      end
   end

`ifdef FETCH_PERF_EN
   // Pops delivered to decode, and instructions thrown away by flushes (queued plus one not-yet-stale in flight).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched <= 32'h0;
         perf_flushed <= 32'h0;
      end else begin
         if (pop) perf_fetched <= perf_fetched + 32'd1;
         if (PCSrc) perf_flushed <= perf_flushed + 32'(count) + 32'(outstanding && !drop);
      end
   end
`endif

endmodule
